// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI_Master between two requester FSMs.
// Optional watchdog: define SPIARB_TIMEOUT_EN.
module spi_master_arbiter #(
  parameter int DataWidth    = 8,
  parameter int TimeoutWidth = 16
) (
  input  logic                 Clk_i,
  input  logic                 Reset_i,
  input  logic                 Req0_i,
  input  logic                 Req1_i,
  output logic                 Gnt0_o,
  output logic                 Gnt1_o,
  input  logic                 Write0_i,
  input  logic                 Write1_i,
  input  logic                 ReadNext0_i,
  input  logic                 ReadNext1_i,
  input  logic [DataWidth-1:0] Data0_i,
  input  logic [DataWidth-1:0] Data1_i,
  input  logic [2:0]           Mode0_i,
  input  logic [2:0]           Mode1_i,
  output logic                 FIFOFull0_o,
  output logic                 FIFOFull1_o,
  output logic                 FIFOEmpty0_o,
  output logic                 FIFOEmpty1_o,
  output logic                 Transmission0_o,
  output logic                 Transmission1_o,
  output logic [DataWidth-1:0] RdData_o,
  output logic                 SPI_Write_o,
  output logic                 SPI_ReadNext_o,
  output logic [DataWidth-1:0] SPI_Data_o,
  output logic                 SPI_CPOL_o,
  output logic                 SPI_CPHA_o,
  output logic                 SPI_LSBFE_o,
  input  logic [DataWidth-1:0] SPI_Data_i,
  input  logic                 SPI_FIFOFull_i,
  input  logic                 SPI_FIFOEmpty_i,
  input  logic                 SPI_Transmission_i,
`ifdef SPIARB_TIMEOUT_EN
  input  logic [TimeoutWidth-1:0] TimeoutPreset_i,
`endif
  output logic                 Timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OWN0,
    S_OWN1,
    S_DRAIN
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_last;
  logic [2:0] r_mode;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_req0;
  logic       w_req1;
  logic       w_blk0;
  logic       w_blk1;
  logic       w_expire;

`ifdef SPIARB_TIMEOUT_EN
  logic [TimeoutWidth-1:0] r_cnt;
  logic                    r_wd_en;
  logic                    r_timeout;
  logic                    r_blk0;
  logic                    r_blk1;
  logic                    w_fire0;
  logic                    w_fire1;

  assign w_expire = r_wd_en && (r_cnt == 1)
                    && (w_gnt0 || w_gnt1);
  assign w_fire0  = w_expire && w_gnt0 && Req0_i;
  assign w_fire1  = w_expire && w_gnt1 && Req1_i;
  assign w_blk0   = r_blk0;
  assign w_blk1   = r_blk1;
  assign Timeout_o = r_timeout;

  // A timed-out owner stays locked out until it lets go of Req.
  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      r_cnt     <= '0;
      r_wd_en   <= 1'b0;
      r_timeout <= 1'b0;
      r_blk0    <= 1'b0;
      r_blk1    <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_next != S_IDLE) begin
        r_cnt   <= TimeoutPreset_i;
        r_wd_en <= |TimeoutPreset_i;
      end else if ((w_gnt0 || w_gnt1) && r_wd_en) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_fire0 || w_fire1)
        r_timeout <= 1'b1;
      if (w_fire0)
        r_blk0 <= 1'b1;
      else if (!Req0_i)
        r_blk0 <= 1'b0;
      if (w_fire1)
        r_blk1 <= 1'b1;
      else if (!Req1_i)
        r_blk1 <= 1'b0;
    end
  end
`else
  assign w_expire  = 1'b0;
  assign w_blk0    = 1'b0;
  assign w_blk1    = 1'b0;
  // No watchdog: the flag is constant 0 for any legal counter width.
  assign Timeout_o = (TimeoutWidth == 0);
`endif

  assign w_req0 = Req0_i && !w_blk0;
  assign w_req1 = Req1_i && !w_blk1;
  assign w_gnt0 = (r_state == S_OWN0);
  assign w_gnt1 = (r_state == S_OWN1);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_req0 && (!w_req1 || r_last))
          w_next = S_OWN0;
        else if (w_req1)
          w_next = S_OWN1;
      end
      S_OWN0: begin
        if (!Req0_i || w_expire)
          w_next = S_DRAIN;
      end
      S_OWN1: begin
        if (!Req1_i || w_expire)
          w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (!SPI_Transmission_i && SPI_FIFOEmpty_i)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_mode  <= 3'b110;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_next == S_OWN0) begin
        r_last <= 1'b0;
        r_mode <= Mode0_i;
      end else if (r_state == S_IDLE && w_next == S_OWN1) begin
        r_last <= 1'b1;
        r_mode <= Mode1_i;
      end
    end
  end

  assign Gnt0_o = w_gnt0;
  assign Gnt1_o = w_gnt1;

  assign SPI_Write_o    = (w_gnt0 && Write0_i)
                       || (w_gnt1 && Write1_i);
  assign SPI_ReadNext_o = (w_gnt0 && ReadNext0_i)
                       || (w_gnt1 && ReadNext1_i);
  assign SPI_Data_o     = w_gnt0 ? Data0_i :
                          w_gnt1 ? Data1_i : '0;

  assign SPI_CPOL_o  = r_mode[2];
  assign SPI_CPHA_o  = r_mode[1];
  assign SPI_LSBFE_o = r_mode[0];

  // Non-owners see a full, busy master so they never push.
  assign FIFOFull0_o     = w_gnt0 ? SPI_FIFOFull_i     : 1'b1;
  assign FIFOEmpty0_o    = w_gnt0 ? SPI_FIFOEmpty_i    : 1'b0;
  assign Transmission0_o = w_gnt0 ? SPI_Transmission_i : 1'b1;
  assign FIFOFull1_o     = w_gnt1 ? SPI_FIFOFull_i     : 1'b1;
  assign FIFOEmpty1_o    = w_gnt1 ? SPI_FIFOEmpty_i    : 1'b0;
  assign Transmission1_o = w_gnt1 ? SPI_Transmission_i : 1'b1;

  assign RdData_o = SPI_Data_i;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter.
// Define SPIARB_TIMEOUT_EN to also exercise the watchdog.
module tb_spi_master_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, gnt0, gnt1;
  logic       wr0, wr1, rn0, rn1;
  logic [7:0] d0, d1;
  logic [2:0] m0, m1;
  logic       ff0, ff1, fe0, fe1, tr0, tr1;
  logic [7:0] rd;
  logic       s_wr, s_rn;
  logic [7:0] s_do;
  logic       cpol, cpha, lsbfe;
  logic [7:0] s_di;
  logic       s_full, s_empty, s_tr;
  logic       tmo;
`ifdef SPIARB_TIMEOUT_EN
  logic [15:0] preset;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_master_arbiter dut (
    .Clk_i(clk), .Reset_i(rst),
    .Req0_i(req0), .Req1_i(req1),
    .Gnt0_o(gnt0), .Gnt1_o(gnt1),
    .Write0_i(wr0), .Write1_i(wr1),
    .ReadNext0_i(rn0), .ReadNext1_i(rn1),
    .Data0_i(d0), .Data1_i(d1),
    .Mode0_i(m0), .Mode1_i(m1),
    .FIFOFull0_o(ff0), .FIFOFull1_o(ff1),
    .FIFOEmpty0_o(fe0), .FIFOEmpty1_o(fe1),
    .Transmission0_o(tr0), .Transmission1_o(tr1),
    .RdData_o(rd),
    .SPI_Write_o(s_wr), .SPI_ReadNext_o(s_rn),
    .SPI_Data_o(s_do),
    .SPI_CPOL_o(cpol), .SPI_CPHA_o(cpha),
    .SPI_LSBFE_o(lsbfe),
    .SPI_Data_i(s_di),
    .SPI_FIFOFull_i(s_full),
    .SPI_FIFOEmpty_i(s_empty),
    .SPI_Transmission_i(s_tr),
`ifdef SPIARB_TIMEOUT_EN
    .TimeoutPreset_i(preset),
`endif
    .Timeout_o(tmo)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (!rst && gnt0 && gnt1) begin
      n_tests++;
      n_fail++;
      $display("FAIL gnt_excl got=11 exp=not11");
    end

  initial begin
    rst = 1'b1;
    {req0, req1, wr0, wr1, rn0, rn1} = '0;
    d0 = 8'h00; d1 = 8'h00;
    m0 = 3'b000; m1 = 3'b000;
    s_di = 8'hA5; s_full = 1'b0;
    s_empty = 1'b1; s_tr = 1'b0;
`ifdef SPIARB_TIMEOUT_EN
    preset = 16'd0;
`endif
    #2;
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_mode", {cpol, cpha, lsbfe}, 3'b110);
    check("rst_tmo", tmo, 0);
    check("rst_busy0", {ff0, fe0, tr0}, 3'b101);
    check("rst_data", s_do, 8'h00);
    step();
    rst = 1'b0;

    // single requester, strobe and mode muxing
    req0 = 1'b1; m0 = 3'b001;
    #1 check("lat_gnt0", gnt0, 0);
    step();
    check("own0_gnt0", gnt0, 1);
    check("own0_mode", {cpol, cpha, lsbfe}, 3'b001);
    check("own0_st0", {ff0, fe0, tr0}, 3'b010);
    check("own0_st1", {ff1, fe1, tr1}, 3'b101);
    check("rddata", rd, 8'hA5);
    wr0 = 1'b1; d0 = 8'h54; rn0 = 1'b1;
    #1 check("wr0", {s_wr, s_rn}, 2'b11);
    check("data0", s_do, 8'h54);
    wr0 = 1'b0; rn0 = 1'b0;
    wr1 = 1'b1; d1 = 8'hFF; m0 = 3'b111;
    #1 check("wr1_ign", s_wr, 0);
    check("data1_ign", s_do, 8'h54);
    step();
    check("mode_hold", {cpol, cpha, lsbfe}, 3'b001);
    req0 = 1'b0; wr1 = 1'b0;
    step();
    check("rel_gnt0", gnt0, 0);
    step();

    // tie after reset, then drain hold
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    m0 = 3'b001; m1 = 3'b010;
    step();
    check("tie_gnt", {gnt0, gnt1}, 2'b10);
    s_tr = 1'b1; s_empty = 1'b0; req0 = 1'b0;
    step();
    check("drain_gnt", {gnt0, gnt1}, 2'b00);
    wr0 = 1'b1; d0 = 8'h54;
    #1 check("drain_wr", s_wr, 0);
    check("drain_data", s_do, 8'h00);
    check("drain_mode", {cpol, cpha, lsbfe}, 3'b001);
    for (int i = 0; i < 4; i++) begin
      step();
      check("drain_hold", gnt1, 0);
    end
    s_tr = 1'b0; s_empty = 1'b1; wr0 = 1'b0;
    step();
    check("idle_gnt1", gnt1, 0);
    step();
    check("own1_gnt1", gnt1, 1);
    check("own1_mode", {cpol, cpha, lsbfe}, 3'b010);
    check("own1_st1", {ff1, fe1, tr1}, 3'b010);

    // round robin alternation
    req1 = 1'b0;
    step();
    req0 = 1'b1; req1 = 1'b1;
    step();
    check("rr_idle", {gnt0, gnt1}, 2'b00);
    step();
    check("rr_a", {gnt0, gnt1}, 2'b10);
    req0 = 1'b0;
    step();
    req0 = 1'b1;
    step();
    step();
    check("rr_b", {gnt0, gnt1}, 2'b01);

    // asynchronous reset mid-ownership
    req0 = 1'b0;
    step();
    check("pre_rst_gnt1", gnt1, 1);
    rst = 1'b1;
    #1 check("arst_gnt1", gnt1, 0);
    check("arst_mode", {cpol, cpha, lsbfe}, 3'b110);
    step();
    rst = 1'b0;
    #1 check("post_rst", gnt1, 0);
    step();
    check("post_rst_gnt1", gnt1, 1);

`ifdef SPIARB_TIMEOUT_EN
    preset = 16'd10;
    req1 = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    step();
    check("wd_gnt0", gnt0, 1);
    for (int i = 0; i < 9; i++) begin
      step();
      check("wd_hold", {gnt0, tmo}, 2'b10);
    end
    step();
    check("wd_fire", {gnt0, tmo}, 2'b01);
    step();
    step();
    check("wd_gnt1", {gnt0, gnt1}, 2'b01);
    req1 = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("wd_block", gnt0, 0);
    end
    req0 = 1'b0;
    step();
    req0 = 1'b1;
    step();
    check("wd_regrant", {gnt0, tmo}, 2'b11);
`endif

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
- Shares one SPI_Master between two sensor application FSMs, e.g. an ADT7310 reader and a second SPI sensor reader in the reconfigurable module.
- Grants the master exclusively to one requester at a time, using round-robin priority.
- Muxes the requester's write/read strobes, data and SPI mode bits to the master.
- Returns FIFO and transmission status only to the granted requester.
- Holds the grant until the requester releases it and the master has drained.

Parameters:
DataWidth, 8, SPI data byte width
TimeoutWidth, 16, width of watchdog counter (used only with SPIARB_TIMEOUT_EN)

Ports:
Clk_i  in  1  clock
Reset_i  in  1  asynchronous reset, active-high
Req0_i / Req1_i  in  1  requester n wants the SPI master; held for the whole transaction
Gnt0_o / Gnt1_o  out  1  requester n owns the SPI master
Write0_i / Write1_i  in  1  requester n SPI_Write strobe
ReadNext0_i / ReadNext1_i  in  1  requester n SPI_ReadNext strobe
Data0_i / Data1_i  in  DataWidth  requester n transmit byte
Mode0_i / Mode1_i  in  3  requester n {CPOL, CPHA, LSBFE}
FIFOFull0_o / FIFOFull1_o  out  1  gated SPI_FIFOFull to requester n
FIFOEmpty0_o / FIFOEmpty1_o  out  1  gated SPI_FIFOEmpty to requester n
Transmission0_o / Transmission1_o  out  1  gated SPI_Transmission to requester n
RdData_o  out  DataWidth  SPI_Data_i broadcast to both requesters
SPI_Write_o, SPI_ReadNext_o  out  1  to SPI_Master
SPI_Data_o  out  DataWidth  to SPI_Master
SPI_CPOL_o, SPI_CPHA_o, SPI_LSBFE_o  out  1  to SPI_Master
SPI_Data_i  in  DataWidth  from SPI_Master
SPI_FIFOFull_i, SPI_FIFOEmpty_i, SPI_Transmission_i  in  1  from SPI_Master
Timeout_o  out  1  sticky watchdog flag (tied 0 without SPIARB_TIMEOUT_EN)

Behaviour:
- States: IDLE, OWN0, OWN1, DRAIN. Registered round-robin pointer Last: 0 or 1, the last owner.
- Reset values: state IDLE, Last=1 so requester 0 wins the first tie, Gnt*=0, mode register=3'b110 (CPOL=1, CPHA=1, LSBFE=0), Timeout_o=0.
- IDLE:
  - Only Req0 set -> OWN0; only Req1 set -> OWN1.
  - Both set -> the requester not equal to Last wins.
  - Gnt asserts on the clock edge after Req is seen (1-cycle latency).
  - On entering OWNn: latch Modén_i into the mode register and set Last=n.
- OWNn:
  - SPI_Write_o = Writen_i; SPI_ReadNext_o = ReadNextn_i; SPI_Data_o = Datan_i. All combinational.
  - Gated status for requester n passes SPI_* straight through.
  - The non-granted requester sees FIFOFull=1, FIFOEmpty=0, Transmission=1 ("busy"). Its strobes are ignored.
  - Reqn_i low -> DRAIN; Gntn drops in the same edge.
- DRAIN:
  - All strobes forced 0.
  - Stays until SPI_Transmission_i=0 and SPI_FIFOEmpty_i=1, then -> IDLE.
  - Leaves no bubble beyond that cycle: the next grant needs one IDLE cycle, so grant-to-grant is at least 2 cycles after drain completes.
- IDLE/DRAIN: SPI_Data_o=0; both requesters see "busy" status.
- Mode outputs come only from the mode register, never combinationally from Mode*_i. They are stable for the whole ownership and through DRAIN.
- Simultaneous events:
  - Owner drops Req while the other raises Req: the other is granted only after DRAIN and IDLE.
  - Owner re-raises Req during DRAIN: it is treated as a new request in IDLE, with round-robin applied.
- Reset mid-transaction: everything returns to reset values immediately (asynchronous). The SPI_Master is reset by the same signal.
- Gnt0_o and Gnt1_o are never both 1 (invariant).

Optional Feature:
- Macro SPIARB_TIMEOUT_EN.
- Enabled:
  - Input TimeoutPreset_i[TimeoutWidth-1:0] is added.
  - A down-counter loads the preset on entry to OWNn and decrements each OWNn cycle.
  - At 0 it forces DRAIN even though Reqn is still high, and sets Timeout_o.
  - The timed-out requester cannot be re-granted until it has dropped Req for at least one cycle.
  - Timeout_o is cleared only by reset.
  - A preset of 0 disables the watchdog.
- Disabled: no counter, no extra port, Timeout_o=0.

Test Plan:
- Reset, then Req0=1 only -> Gnt0=1 one cycle later. Mode0=3'b001 → SPI_CPOL/CPHA/LSBFE = 0/0/1. Write0 pulse with Data0=8'h54 → SPI_Write_o=1, SPI_Data_o=8'h54.
- Req0 and Req1 both raised in the same cycle after reset -> Gnt0 first. Drop Req0, master idle+empty -> Gnt1 after DRAIN+IDLE. Both requesting again -> Gnt0 (round-robin alternates).
- While Gnt0: Write1=1, Data1=8'hFF -> SPI_Write_o stays 0. Requester 1 sees FIFOFull1=1, Transmission1=1.
- Req0 drops while SPI_Transmission_i=1 for 5 cycles -> remains in DRAIN 5 cycles, no grant. Gnt1 only after Transmission=0 and FIFOEmpty=1.
- Reset asserted in OWN1 mid-transfer -> Gnt1=0 and mode=3'b110 immediately. After release, Req1 -> Gnt1 in 1 cycle.
- With SPIARB_TIMEOUT_EN, TimeoutPreset=10, Req0 held -> Gnt0 drops after 10 owned cycles, Timeout_o=1, Req1 granted. Req0 still high is not re-granted until toggled.
